mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 8 +
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared word width, arbiter states and default data streak limit
`ifndef WORD
`define WORD [31:0]
`endif
package mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;
   localparam int MAX_DATA_STREAK_DEF = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access
`ifndef WORD
`define WORD [31:0]
`endif
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       if_req,
   input  logic `WORD if_addr,
   output logic `WORD if_rdata,
   output logic       if_valid,
   input  logic       d_req,
   input  logic       d_we,
   input  logic `WORD d_addr,
   input  logic `WORD d_wdata,
   output logic `WORD d_rdata,
   output logic       d_valid,
   output logic       mem_req,
   output logic       mem_we,
   output logic `WORD mem_addr,
   output logic `WORD mem_wdata,
   input  logic `WORD mem_rdata,
   input  logic       mem_ack
);
   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   state_e        state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic `WORD    addr_q, addr_d, wdata_q, wdata_d;
   logic `WORD    if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic          we_q, we_d, if_valid_q, if_valid_d, d_valid_q, d_valid_d;
   logic          grant_d, grant_f, idle, streak_full;
   // state and datapath registers, all cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         streak_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         if_valid_q <= if_valid_d;
         d_valid_q  <= d_valid_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end
   // arbitrate only in IDLE; a busy state waits for mem_ack regardless of requests
   always_comb begin
      idle        = state_q == IDLE;
      streak_full = streak_q == SW'(MAX_DATA_STREAK);
      grant_d     = d_req && (!streak_full || !if_req);
      grant_f     = if_req && !grant_d;
      state_d     = idle ? (grant_d ? DATA : grant_f ? FETCH : IDLE) : mem_ack ? IDLE : state_q;
   end
   // latch the winner, track the data streak, capture completions
   always_comb begin
      addr_d     = idle && grant_d ? d_addr : idle && grant_f ? if_addr : addr_q;
      we_d       = idle && (grant_d || grant_f) ? grant_d && d_we : we_q;
      wdata_d    = idle && grant_d ? d_wdata : wdata_q;
      streak_d   = !idle ? streak_q : (!if_req || grant_f) ? '0 :
                   (grant_d && !streak_full) ? streak_q + SW'(1) : streak_q;
      if_valid_d = state_q == FETCH && mem_ack;
      d_valid_d  = state_q == DATA && mem_ack;
      if_rdata_d = if_valid_d ? mem_rdata : if_rdata_q;
      d_rdata_d  = d_valid_d && !we_q ? mem_rdata : d_rdata_q;
   end
   // memory port and completion outputs come straight from registers
   always_comb begin
      mem_req   = !idle;
      mem_we    = state_q == DATA && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if_valid  = if_valid_q;
      d_valid   = d_valid_q;
      if_rdata  = if_rdata_q;
      d_rdata   = d_rdata_q;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of the fetch/data memory arbiter
`ifndef WORD
`define WORD [31:0]
`endif
module tb_mem_arbiter;
   localparam int MAXS = 4;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
   logic `WORD if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic `WORD if_rdata, d_rdata, mem_addr, mem_wdata;
   logic       if_valid, d_valid, mem_req, mem_we;
   int         total = 0, bad = 0;
   bit         busy, side_d, m_we, e_ifv, e_dv;
   logic `WORD m_addr, m_wd, e_ifr, e_dr;
   int         streak, dv_run;
   bit         fetch_seen;
   bit         f_if, f_d, f_dwe;
   logic `WORD f_ia, f_da, f_dwd;

   mem_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic `WORD got, input logic `WORD exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      busy = 0; side_d = 0; m_we = 0; e_ifv = 0; e_dv = 0;
      m_addr = '0; m_wd = '0; e_ifr = '0; e_dr = '0; streak = 0;
   endtask

   task automatic check_outputs();
      check("mem_req", mem_req, busy);
      if (busy) begin
         check("mem_addr", mem_addr, m_addr);
         check("mem_we", mem_we, side_d && m_we);
         if (side_d && m_we) check("mem_wdata", mem_wdata, m_wd);
      end
      check("if_valid", if_valid, e_ifv);
      check("d_valid", d_valid, e_dv);
      check("if_rdata", if_rdata, e_ifr);
      check("d_rdata", d_rdata, e_dr);
   endtask

   // what one rising edge should do, from the arbitration and completion rules
   task automatic advance();
      bit g_d, g_f;
      e_ifv = 0; e_dv = 0;
      if (busy) begin
         if (mem_ack) begin
            busy = 0;
            if (side_d) begin
               e_dv = 1;
               if (!m_we) e_dr = mem_rdata;
            end else begin
               e_ifv = 1;
               e_ifr = mem_rdata;
            end
         end
      end else begin
         g_d = 0;
         if (d_req && streak < MAXS) g_d = 1;
         else if (!if_req && d_req) g_d = 1;
         g_f = if_req && !g_d;
         if (g_d || g_f) begin
            busy = 1; side_d = g_d;
            m_addr = g_d ? d_addr : if_addr;
            m_we = g_d && d_we;
            m_wd = d_wdata;
         end
         if (!if_req || g_f) streak = 0;
         else if (g_d && streak < MAXS) streak++;
      end
   endtask

   task automatic cycle(input int ack_pct, input int req_pct, input bit stick);
      @(negedge clk);
      check_outputs();
      if (stick) begin
         if (d_valid) dv_run++;
         if (if_valid) begin
            if (fetch_seen) check("streak_run", dv_run, MAXS);
            fetch_seen = 1; dv_run = 0;
         end
      end
      if (e_ifv) if_req = 0;
      if (e_dv) d_req = 0;
      if (!if_req && (stick || $urandom_range(99) < req_pct)) begin
         if_req = 1; if_addr = $urandom;
      end
      if (!d_req && (stick || $urandom_range(99) < req_pct)) begin
         d_req = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      if (!stick && req_pct > 0 && busy && $urandom_range(99) < 4) begin
         if (side_d) d_req = 0;
         else if_req = 0;
      end
      if (f_if) begin if_req = 1; if_addr = f_ia; f_if = 0; end
      if (f_d) begin d_req = 1; d_we = f_dwe; d_addr = f_da; d_wdata = f_dwd; f_d = 0; end
      mem_ack = busy ? ($urandom_range(99) < ack_pct) : ($urandom_range(19) == 0);
      mem_rdata = $urandom;
      advance();
   endtask

   task automatic reset_mid();
      int n = 0;
      while (!busy && n < 50) begin
         cycle(0, 60, 0);
         n++;
      end
      @(posedge clk);
      #1 check("rst_busy", mem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, '0);
      check("rst_mem_wdata", mem_wdata, '0);
      model_reset();
      if_req = 0; d_req = 0; mem_ack = 1;
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      advance();
   endtask

   initial begin
      model_reset();
      dv_run = 0; fetch_seen = 0; f_if = 0; f_d = 0;
      #2 check_outputs();
      check("reset_mem_addr", mem_addr, '0);
      check("reset_mem_wdata", mem_wdata, '0);
      check("reset_mem_we", mem_we, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      advance();
      f_if = 1; f_ia = 32'h100;
      repeat (8) cycle(40, 0, 0);
      f_if = 1; f_ia = 32'h104; f_d = 1; f_dwe = 0; f_da = 32'h200; f_dwd = '0;
      repeat (16) cycle(40, 0, 0);
      f_d = 1; f_dwe = 1; f_da = 32'h300; f_dwd = 32'hDEADBEEF;
      repeat (8) cycle(40, 0, 0);
      reset_mid();
      repeat (4) cycle(50, 0, 0);
      fetch_seen = 0; dv_run = 0;
      repeat (400) cycle(35, 0, 1);
      repeat (200) cycle(100, 100, 0);
      repeat (2000) cycle(35, 30, 0);
      reset_mid();
      repeat (20) cycle(50, 40, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
